// File: rtl/histogram_sequencer_pkg.sv
// Shared definitions for the histogram frame sequencer.
// Holds the default frame geometry, frame-buffer address width, the
// command holdoff length, the sequencer state encoding and the median
// threshold helper.
package histogram_sequencer_pkg;

  localparam int unsigned IMWIDTH  = 240;
  localparam int unsigned IMHEIGHT = 180;
  localparam int unsigned AW       = 16;
  localparam int unsigned HOLDOFF  = 2;
  localparam int unsigned BIN_W    = 8;
  localparam int unsigned COUNT_W  = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_CLRW,
    S_SCAN,
    S_FLUSH,
    S_STOP,
    S_RD,
    S_RDW,
    S_DONE
  } seq_state_t;

  // (count+1)>>1 without losing the carry out of the 16-bit count.
  function automatic logic [COUNT_W-1:0] median_threshold(input logic [COUNT_W-1:0] count);
    logic [COUNT_W:0] sum;
    sum = {1'b0, count} + (COUNT_W+1)'(1);
    return sum[COUNT_W:1];
  endfunction

endpackage

// File: rtl/histogram_sequencer_if.sv
// Bus between the sequencer and its two neighbours: the frame-buffer read
// port (fbRdEn/fbAddr/fbData) and computeHistogram (addresses, pixel
// increment, command pulses, status flags, readback streams).
//   master : sequencer side
//   slave  : frame buffer / computeHistogram side
interface histogram_sequencer_if
  import histogram_sequencer_pkg::*;
#(
  parameter int unsigned AW = histogram_sequencer_pkg::AW
);
  logic             fbRdEn;
  logic [AW-1:0]    fbAddr;
  logic             fbData;
  logic [BIN_W-1:0] histXAddress;
  logic [BIN_W-1:0] histYAddress;
  logic             histPixelData;
  logic             histStart;
  logic             histStop;
  logic             histClear;
  logic             histRead;
  logic             histReady;
  logic             histCleared;
  logic [BIN_W-1:0] histXOut;
  logic [BIN_W-1:0] histYOut;
  logic             histXValid;
  logic             histYValid;

  modport master (
    output fbRdEn, fbAddr, histXAddress, histYAddress, histPixelData,
           histStart, histStop, histClear, histRead,
    input  fbData, histReady, histCleared, histXOut, histYOut, histXValid, histYValid
  );

  modport slave (
    input  fbRdEn, fbAddr, histXAddress, histYAddress, histPixelData,
           histStart, histStop, histClear, histRead,
    output fbData, histReady, histCleared, histXOut, histYOut, histXValid, histYValid
  );
endinterface

// File: rtl/histogram_sequencer_tracker.sv
// hist_median_tracker: reduces one histogram readback stream to its median.
// Accumulates bin values beat by beat and latches the index of the first
// beat whose running sum reaches the threshold.
//   clk, reset : clock, synchronous active-high reset
//   init       : clears sum, index, found flag and median
//   threshold  : target cumulative count
//   valid, bin : readback beat qualifier and bin value
//   median     : latched bin index, 0 until found
module hist_median_tracker
  import histogram_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [COUNT_W-1:0] threshold,
  input  logic               valid,
  input  logic [BIN_W-1:0]   bin,
  output logic [BIN_W-1:0]   median
);
  logic [COUNT_W:0] cum;
  logic [COUNT_W:0] cum_next;
  logic [BIN_W-1:0] idx;
  logic             found;

  assign cum_next = cum + {{(COUNT_W+1-BIN_W){1'b0}}, bin};

  always_ff @(posedge clk) begin
    if (reset || init) begin
      cum    <= '0;
      idx    <= '0;
      found  <= 1'b0;
      median <= '0;
    end else if (valid) begin
      cum <= cum_next;
      idx <= idx + BIN_W'(1);
      if (!found && (cum_next >= {1'b0, threshold})) begin
        found  <= 1'b1;
        median <= idx;
      end
    end
  end
endmodule

// File: rtl/histogram_sequencer.sv
// histogram_sequencer: per-frame controller for computeHistogram.
// Clears the projection histograms, rasters the frame buffer into them,
// stops, reads them back and reduces each stream to a median coordinate.
//   clk, reset          : clock, synchronous active-high reset
//   start               : frame request, ignored while busy
//   busy, done          : frame in progress / one-cycle completion pulse
//   bus                 : frame-buffer and computeHistogram signals (master)
//   pixelCount          : set pixels in the last frame
//   xMedian, yMedian    : median bins of the last frame
//   empty               : last frame had no set pixels
module histogram_sequencer
  import histogram_sequencer_pkg::*;
#(
  parameter int unsigned IMWIDTH  = histogram_sequencer_pkg::IMWIDTH,
  parameter int unsigned IMHEIGHT = histogram_sequencer_pkg::IMHEIGHT,
  parameter int unsigned AW       = histogram_sequencer_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  histogram_sequencer_if.master bus,
  output logic [COUNT_W-1:0]   pixelCount,
  output logic [BIN_W-1:0]     xMedian,
  output logic [BIN_W-1:0]     yMedian,
  output logic                 empty
);
  localparam logic [BIN_W-1:0] X_LAST = BIN_W'(IMWIDTH - 1);
  localparam logic [BIN_W-1:0] Y_LAST = BIN_W'(IMHEIGHT - 1);

  seq_state_t       state, state_next;
  logic             cmd_sent, cmd_sent_next;
  logic [1:0]       hold;
  logic             ready_ok;
  logic             clear_p, start_p, stop_p, read_p;
  logic             rd_en, rd_en_d1;
  logic [BIN_W-1:0] x_cnt, y_cnt, x_d1, y_d1;
  logic [AW-1:0]    addr;
  logic             last_pixel;
  logic             pixel;
  logic             accept;
  logic             reading;

  assign accept     = (state == S_IDLE) && start;
  assign ready_ok   = bus.histReady && (hold == 2'd0);
  assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign pixel      = bus.fbData & rd_en_d1;
  assign reading    = (state == S_RD) || (state == S_RDW);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  assign bus.fbRdEn        = rd_en;
  assign bus.fbAddr        = addr;
  assign bus.histXAddress  = x_d1;
  assign bus.histYAddress  = y_d1;
  assign bus.histPixelData = pixel;
  assign bus.histClear     = clear_p;
  assign bus.histStart     = start_p;
  assign bus.histStop      = stop_p;
  assign bus.histRead      = read_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd_sent <= 1'b0;
    end else begin
      state    <= state_next;
      cmd_sent <= cmd_sent_next;
    end
  end

  // SCAN and STOP each hold two phases: issue the command pulse once
  // histReady allows it, then run (SCAN) or wait for idle (STOP).
  // cmd_sent separates the phases and is cleared on entry to either state.
  always_comb begin
    state_next    = state;
    cmd_sent_next = cmd_sent;
    clear_p       = 1'b0;
    start_p       = 1'b0;
    stop_p        = 1'b0;
    read_p        = 1'b0;
    rd_en         = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_next = S_CLR;
      S_CLR:   if (ready_ok) begin
                 clear_p    = 1'b1;
                 state_next = S_CLRW;
               end
      S_CLRW:  if (ready_ok && bus.histCleared) begin
                 state_next    = S_SCAN;
                 cmd_sent_next = 1'b0;
               end
      S_SCAN:  if (!cmd_sent) begin
                 if (ready_ok) begin
                   start_p       = 1'b1;
                   cmd_sent_next = 1'b1;
                 end
               end else begin
                 rd_en = 1'b1;
                 if (last_pixel) state_next = S_FLUSH;
               end
      S_FLUSH: begin
                 state_next    = S_STOP;
                 cmd_sent_next = 1'b0;
               end
      S_STOP:  if (!cmd_sent) begin
                 if (ready_ok) begin
                   stop_p        = 1'b1;
                   cmd_sent_next = 1'b1;
                 end
               end else if (ready_ok) begin
                 state_next = S_RD;
               end
      S_RD:    if (ready_ok) begin
                 read_p     = 1'b1;
                 state_next = S_RDW;
               end
      S_RDW:   if (ready_ok) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status flags from computeHistogram are stale right after a command.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= 2'd0;
    end else if (clear_p || start_p || stop_p || read_p) begin
      hold <= 2'(HOLDOFF);
    end else if (hold != 2'd0) begin
      hold <= hold - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state == S_IDLE)) begin
      x_cnt <= '0;
      y_cnt <= '0;
      addr  <= '0;
    end else if (rd_en) begin
      addr <= addr + AW'(1);
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + BIN_W'(1);
      end else begin
        x_cnt <= x_cnt + BIN_W'(1);
      end
    end
  end

  // Stage 2 aligns the bin address with the frame-buffer data beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_d1 <= 1'b0;
      x_d1     <= '0;
      y_d1     <= '0;
    end else begin
      rd_en_d1 <= rd_en;
      x_d1     <= x_cnt;
      y_d1     <= y_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      pixelCount <= '0;
    end else if (pixel) begin
      pixelCount <= pixelCount + COUNT_W'(1);
    end
  end

  // Latched on the way into DONE so it is valid in the done cycle itself.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      empty <= 1'b0;
    end else if ((state == S_RDW) && (state_next == S_DONE)) begin
      empty <= (pixelCount == '0);
    end
  end

  hist_median_tracker x_tracker (
    .clk       (clk),
    .reset     (reset),
    .init      (accept),
    .threshold (median_threshold(pixelCount)),
    .valid     (bus.histXValid && reading),
    .bin       (bus.histXOut),
    .median    (xMedian)
  );

  hist_median_tracker y_tracker (
    .clk       (clk),
    .reset     (reset),
    .init      (accept),
    .threshold (median_threshold(pixelCount)),
    .valid     (bus.histYValid && reading),
    .bin       (bus.histYOut),
    .median    (yMedian)
  );
endmodule
